// File: rtl/capture_pkg.sv
// Shared types and constants for the capture sequencer.
// Optional decimation is selected with CAPTURE_DECIMATE_EN.
package capture_pkg;

  localparam int CNT_BITS_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } capture_state_t;

  function automatic logic state_is_busy(input capture_state_t s);
    return (s == ST_PRE) || (s == ST_WAIT_TRIG) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/sample_divider.sv
// Sample-strobe decimator: passes one of every (div+1) sample_en pulses.
// Only instantiated when CAPTURE_DECIMATE_EN is defined.
module sample_divider #(
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_load,
  input  logic [CNT_BITS-1:0] i_div,
  input  logic                i_clear,
  input  logic                i_sample_en,
  output logic                o_qs,
  output logic [CNT_BITS-1:0] o_div
);

  logic [CNT_BITS-1:0] r_div;
  logic [CNT_BITS-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
      r_cnt <= '0;
    end else begin
      if (i_load) begin
        r_div <= i_div;
      end
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_sample_en) begin
        // >= keeps the counter bounded even if the divisor shrinks mid-count
        r_cnt <= (r_cnt >= r_div) ? '0 : r_cnt + 1'b1;
      end
    end
  end

  assign o_qs  = i_sample_en && (r_cnt == '0);
  assign o_div = r_div;

endmodule

// File: rtl/capture_sequencer.sv
// Capture run controller for a circular sample buffer with pre/post trigger depths.
// Define CAPTURE_DECIMATE_EN to add the div_reg_in/div_reg_out strobe decimator.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int CNT_BITS = CNT_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [CNT_BITS-1:0] pre_reg_in,
  input  logic [CNT_BITS-1:0] post_reg_in,
`ifdef CAPTURE_DECIMATE_EN
  input  logic [CNT_BITS-1:0] div_reg_in,
  output logic [CNT_BITS-1:0] div_reg_out,
`endif
  input  logic                arm,
  input  logic                abort,
  input  logic                sample_en,
  input  logic                trig,
  output logic [CNT_BITS-1:0] pre_reg_out,
  output logic [CNT_BITS-1:0] post_reg_out,
  output logic                mem_we,
  output logic [CNT_BITS-1:0] wr_addr,
  output logic [CNT_BITS-1:0] trig_addr,
  output logic [CNT_BITS-1:0] start_addr,
  output logic                busy,
  output logic                done,
  output logic [2:0]          state
);

  capture_state_t      r_state;
  capture_state_t      w_state_nxt;

  logic [CNT_BITS-1:0] r_pre;
  logic [CNT_BITS-1:0] r_post;
  logic [CNT_BITS-1:0] r_wr_addr;
  logic [CNT_BITS-1:0] r_trig_addr;
  logic [CNT_BITS-1:0] r_fill_cnt;
  logic [CNT_BITS-1:0] r_post_cnt;

  logic                w_idle_like;
  logic                w_busy;
  logic                w_cfg_load;
  logic                w_arm_go;
  logic                w_qs;
  logic                w_we;
  logic                w_trig_hit;
  logic [CNT_BITS-1:0] w_pre_eff;
  logic [CNT_BITS-1:0] w_fill_inc;
  logic [CNT_BITS-1:0] w_post_inc;

`ifdef CAPTURE_DECIMATE_EN
  sample_divider #(
    .CNT_BITS (CNT_BITS)
  ) u_sample_divider (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_cfg_load),
    .i_div       (div_reg_in),
    .i_clear     (w_arm_go),
    .i_sample_en (sample_en),
    .o_qs        (w_qs),
    .o_div       (div_reg_out)
  );
`else
  assign w_qs = sample_en;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
    w_busy      = state_is_busy(r_state);
    w_cfg_load  = wr_en && w_idle_like;
    w_arm_go    = arm && w_idle_like && !abort;
    // a config written in the arming cycle applies to that same run
    w_pre_eff   = w_cfg_load ? pre_reg_in : r_pre;
    w_we        = w_qs && w_busy && !abort;
    w_trig_hit  = (r_state == ST_WAIT_TRIG) && w_we && trig;
    w_fill_inc  = r_fill_cnt + 1'b1;
    w_post_inc  = r_post_cnt + 1'b1;
    w_state_nxt = r_state;

    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            w_state_nxt = (w_pre_eff == '0) ? ST_WAIT_TRIG : ST_PRE;
          end
        end
        ST_PRE: begin
          if (w_we && (w_fill_inc == r_pre)) begin
            w_state_nxt = ST_WAIT_TRIG;
          end
        end
        ST_WAIT_TRIG: begin
          if (w_trig_hit) begin
            w_state_nxt = (r_post == '0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (w_we && (w_post_inc == r_post)) begin
            w_state_nxt = ST_DONE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre       <= '0;
      r_post      <= '0;
      r_wr_addr   <= '0;
      r_trig_addr <= '0;
      r_fill_cnt  <= '0;
      r_post_cnt  <= '0;
    end else begin
      if (w_cfg_load) begin
        r_pre  <= pre_reg_in;
        r_post <= post_reg_in;
      end
      if (w_arm_go) begin
        r_wr_addr  <= '0;
        r_fill_cnt <= '0;
        r_post_cnt <= '0;
      end else begin
        if (w_we) begin
          r_wr_addr <= r_wr_addr + 1'b1;
        end
        if (w_we && (r_state == ST_PRE)) begin
          r_fill_cnt <= w_fill_inc;
        end
        if (w_we && (r_state == ST_POST)) begin
          r_post_cnt <= w_post_inc;
        end
        if (w_trig_hit) begin
          r_trig_addr <= r_wr_addr;
        end
      end
    end
  end

  // start_addr wraps naturally when pre + post + 1 exceeds the buffer depth
  assign start_addr   = r_trig_addr - r_pre;
  assign pre_reg_out  = r_pre;
  assign post_reg_out = r_post;
  assign mem_we       = w_we;
  assign wr_addr      = r_wr_addr;
  assign trig_addr    = r_trig_addr;
  assign busy         = w_busy;
  assign done         = (r_state == ST_DONE);
  assign state        = r_state;

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
Parametrised successor to the analyzer's sample counter: controls one capture run into a circular sample buffer with separate pre-trigger and post-trigger depths. Generates buffer write address and write enable, latches the trigger address, and reports the address of the oldest valid sample for readout. Sits between the trigger unit and sample RAM; config registers are loaded by the host interface.

Parameters:
CNT_BITS, 8, address and count width; buffer depth = 2**CNT_BITS.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
wr_en  in  1  load config registers (only honoured in IDLE/DONE)
pre_reg_in  in  CNT_BITS  pre-trigger sample count
post_reg_in  in  CNT_BITS  post-trigger sample count (excludes trigger sample)
arm  in  1  start capture (pulse)
abort  in  1  cancel capture (pulse)
sample_en  in  1  sample strobe
trig  in  1  trigger condition
pre_reg_out / post_reg_out  out  CNT_BITS  config readback
mem_we  out  1  buffer write enable (combinational)
wr_addr  out  CNT_BITS  current buffer write address (registered)
trig_addr  out  CNT_BITS  address of trigger sample
start_addr  out  CNT_BITS  trig_addr - pre_reg mod 2**CNT_BITS
busy  out  1  state is PRE, WAIT_TRIG or POST
done  out  1  state is DONE
state  out  3  encoded state for debug

Behaviour:
- Reset: all registers and outputs 0, state IDLE; async assert, sync-to-clk release assumed.
- States: IDLE, PRE, WAIT_TRIG, POST, DONE.
- Qualified strobe qs = sample_en (see optional feature). mem_we = qs && busy && !abort; zero latency, write lands at current wr_addr; wr_addr increments on each write, wraps 2**CNT_BITS-1 -> 0.
- IDLE/DONE + arm: wr_addr <= 0, fill/post counters <= 0; next state PRE, or WAIT_TRIG if pre_reg == 0. done clears.
- PRE: each write increments fill count; on write making fill == pre_reg -> WAIT_TRIG. trig ignored.
- WAIT_TRIG: writes continue, wrapping. trig && qs: this sample is the trigger sample, written; trig_addr <= wr_addr; -> POST, or DONE if post_reg == 0. trig without qs ignored.
- POST: each write increments post count; on write making post == post_reg -> DONE.
- DONE: no writes; wr_addr, trig_addr hold until arm.
- abort in any state -> IDLE next cycle; abort beats arm and sample_en in same cycle. arm while busy ignored.
- wr_en outside IDLE/DONE ignored. wr_en and arm same cycle: new config loaded and used by that run.
- pre_reg + post_reg + 1 > 2**CNT_BITS: oldest samples overwritten; start_addr formula unchanged (no error flag).

Optional Feature:
Macro CAPTURE_DECIMATE_EN. Defined: adds div_reg_in/div_reg_out (CNT_BITS), loaded with wr_en; divider counter cleared on arm; qs = sample_en && div_cnt == 0; div_cnt counts sample_en pulses 0..div_reg then wraps, so one of every div_reg+1 strobes is stored; trig evaluated only on qs. Undefined: ports absent, qs = sample_en.

Decomposition:
- Package capture_pkg: capture_state_t enum (3-bit, IDLE=0, PRE=1, WAIT_TRIG=2, POST=3, DONE=4), default CNT_BITS constant.
- Sub-module sample_divider (only instantiated under CAPTURE_DECIMATE_EN): divisor register, counter, qs output.

Test Plan:
(CNT_BITS=4)
- pre=3, post=2, arm, continuous sample_en, trig on 6th strobe -> writes addr 0..5, trig_addr=5, writes 6,7, DONE cycle after addr 7, start_addr=2.
- pre=2, post=3, trig on 20th strobe -> wr_addr wraps 15->0, trig_addr=3, writes 4,5,6, start_addr=1, done=1.
- pre=0, post=0, arm, trig on first strobe -> single write addr 0, DONE next cycle, trig_addr=0, start_addr=0.
- pre=4, trig held high from arm -> no trigger during strobes 1-4; WAIT_TRIG after 4th; 5th strobe is trigger, trig_addr=4.
- abort in POST coincident with sample_en -> mem_we=0 that cycle, IDLE next; wr_en then loads pre=7 and pre_reg_out=7; reset asserted mid-PRE -> all outputs 0 immediately.
- CAPTURE_DECIMATE_EN, div=2, pre=1, post=1 -> writes on strobes 1,4,7 only; trig on strobe 4 -> trig_addr=1.
